// File: rtl/uart_channel.sv
// uart_channel: full-duplex UART channel with configurable frame format, baud divisor and TX/RX FIFOs
module uart_channel #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS = 8,
    parameter int PARITY = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_overrun,
    input  logic                 rx_overrun_clr
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic ODD = PARITY == 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [PW:0] tx_wp, tx_rp;
    logic tx_empty, tx_push, tx_pop, tx_end;
    state_t tx_state, tx_nxt;
    logic [CW-1:0] tx_cnt;
    logic [BW-1:0] tx_bit;
    logic [DATA_BITS-1:0] tx_byte;
    logic [DATA_BITS+1:0] rx_mem [FIFO_DEPTH];
    logic [PW:0] rx_wp, rx_rp;
    logic rx_empty, rx_full, rx_pop, rx_wr, rx_smp, rx_fall;
    logic rx_s1, rx_s2, rx_q, rx_par, rx_push;
    state_t rx_state, rx_nxt;
    logic [CW-1:0] rx_cnt;
    logic [BW-1:0] rx_bit;
    logic [DATA_BITS-1:0] rx_sh;
    logic [DATA_BITS+1:0] rx_entry;
    assign tx_empty = tx_wp == tx_rp;
    assign tx_ready = !(tx_wp[PW] != tx_rp[PW] && tx_wp[PW-1:0] == tx_rp[PW-1:0]);
    assign tx_push = tx_valid && tx_ready;
    assign tx_end = tx_cnt == CW'(CLKS_PER_BIT - 1);
    always_ff @(posedge clk) if (tx_push) tx_mem[tx_wp[PW-1:0]] <= tx_data;
    always_comb begin
        tx_nxt = tx_state;
        tx_pop = 1'b0;
        case (tx_state)
            IDLE: begin
                tx_nxt = tx_empty ? IDLE : START;
                tx_pop = !tx_empty;
            end
            START: tx_nxt = tx_end ? DATA : START;
            DATA: if (tx_end && tx_bit == BW'(DATA_BITS - 1)) tx_nxt = PARITY != 0 ? PAR : STOP;
            PAR: tx_nxt = tx_end ? STOP : PAR;
            STOP: if (tx_end && tx_bit == BW'(STOP_BITS - 1)) begin
                tx_nxt = tx_empty ? IDLE : START;
                tx_pop = !tx_empty;
            end
            default: tx_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= IDLE;
            tx_wp <= '0;
            tx_rp <= '0;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_byte <= '0;
            tx <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            tx_state <= tx_nxt;
            tx_wp <= tx_push ? tx_wp + (PW+1)'(1) : tx_wp;
            tx_rp <= tx_pop ? tx_rp + (PW+1)'(1) : tx_rp;
            tx_cnt <= (tx_state == IDLE || tx_end) ? '0 : tx_cnt + CW'(1);
            tx_bit <= tx_nxt != tx_state ? '0 : tx_end ? tx_bit + BW'(1) : tx_bit;
            tx_byte <= tx_pop ? tx_mem[tx_rp[PW-1:0]] : tx_byte;
            tx <= tx_state == START ? 1'b0 : tx_state == DATA ? tx_byte[tx_bit] :
                  tx_state == PAR ? ^tx_byte ^ ODD : 1'b1;
            tx_busy <= tx_state != IDLE || !tx_empty;
        end
    end
    // start sample lands mid start bit; every later sample is one full bit further on
    assign rx_smp = rx_state == START ? rx_cnt == CW'(CLKS_PER_BIT / 2) : rx_cnt == CW'(CLKS_PER_BIT - 1);
    assign rx_fall = rx_q && !rx_s2;
    always_comb begin
        rx_nxt = rx_state;
        case (rx_state)
            IDLE: rx_nxt = rx_fall ? START : IDLE;
            START: if (rx_smp) rx_nxt = rx_s2 ? IDLE : DATA;
            DATA: if (rx_smp && rx_bit == BW'(DATA_BITS - 1)) rx_nxt = PARITY != 0 ? PAR : STOP;
            PAR: rx_nxt = rx_smp ? STOP : PAR;
            STOP: rx_nxt = rx_smp ? IDLE : STOP;
            default: rx_nxt = IDLE;
        endcase
    end
    assign rx_empty = rx_wp == rx_rp;
    assign rx_full = rx_wp[PW] != rx_rp[PW] && rx_wp[PW-1:0] == rx_rp[PW-1:0];
    assign rx_valid = !rx_empty;
    assign rx_pop = rx_valid && rx_ready;
    assign rx_wr = rx_push && (!rx_full || rx_pop);
    assign {rx_frame_err, rx_parity_err, rx_data} = rx_empty ? '0 : rx_mem[rx_rp[PW-1:0]];
    always_ff @(posedge clk) if (rx_wr) rx_mem[rx_wp[PW-1:0]] <= rx_entry;
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_q <= 1'b1;
            rx_state <= IDLE;
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_sh <= '0;
            rx_par <= 1'b0;
            rx_push <= 1'b0;
            rx_entry <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
            rx_overrun <= 1'b0;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_q <= rx_s2;
            rx_state <= rx_nxt;
            rx_cnt <= rx_state == IDLE ? CW'(1) : rx_smp ? '0 : rx_cnt + CW'(1);
            rx_bit <= rx_state != DATA ? '0 : rx_smp ? rx_bit + BW'(1) : rx_bit;
            rx_sh <= (rx_state == DATA && rx_smp) ? {rx_s2, rx_sh[DATA_BITS-1:1]} : rx_sh;
            rx_par <= (rx_state == PAR && rx_smp) ? rx_s2 : rx_par;
            rx_push <= rx_state == STOP && rx_smp;
            rx_entry <= {!rx_s2, (PARITY != 0) && (rx_par != (^rx_sh ^ ODD)), rx_sh};
            rx_wp <= rx_wr ? rx_wp + (PW+1)'(1) : rx_wp;
            rx_rp <= rx_pop ? rx_rp + (PW+1)'(1) : rx_rp;
            rx_overrun <= (rx_push && !rx_wr) ? 1'b1 : rx_overrun_clr ? 1'b0 : rx_overrun;
        end
    end
endmodule
